// File: rtl/card_dealer_pkg.sv
// Shared types and helpers for the blackjack card dealer.
// Card/rank widths, deck constants, FSM states, point mapping.
package card_dealer_pkg;

  localparam int CARD_W    = 5;
  localparam int RANK_W    = 4;
  localparam int CNT_W     = 6;
  localparam int DECK_SIZE = 52;
  localparam int LFSR_W    = 16;

  localparam logic [CARD_W-1:0] ACE_POINTS  = 5'd11;
  localparam logic [CARD_W-1:0] FACE_POINTS = 5'd10;
  localparam logic [RANK_W-1:0] MAX_RANK    = 4'd13;

  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  typedef enum logic {
    PLAYER = 1'b0,
    DEALER = 1'b1
  } dealTarget_e;

  typedef enum logic [2:0] {
    FILL,
    SHUFFLE,
    READY,
    LOAD,
    STROBE,
    EMPTY
  } dealerState_e;

  typedef struct packed {
    logic [RANK_W-1:0] rank;
    logic [CARD_W-1:0] points;
  } card_t;

  function automatic logic [CARD_W-1:0] rankToPoints(
    input logic [RANK_W-1:0] rank
  );
    logic [CARD_W-1:0] pts;
    unique case (1'b1)
      (rank == 4'd1): pts = ACE_POINTS;
      (rank > 4'd10): pts = FACE_POINTS;
      default:        pts = {1'b0, rank};
    endcase
    return pts;
  endfunction

  // Smallest all-ones mask covering 0..idx.
  function automatic logic [CNT_W-1:0] shuffleMask(
    input logic [CNT_W-1:0] idx
  );
    logic [CNT_W-1:0] m;
    if (idx >= 6'd32)      m = 6'd63;
    else if (idx >= 6'd16) m = 6'd31;
    else if (idx >= 6'd8)  m = 6'd15;
    else if (idx >= 6'd4)  m = 6'd7;
    else if (idx >= 6'd2)  m = 6'd3;
    else                   m = 6'd1;
    return m;
  endfunction

endpackage

// File: rtl/card_dealer_shuffle_lfsr.sv
// 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) for the shuffle.
// Emits the low bits masked down to the current candidate range.
module card_shuffle_lfsr
  import card_dealer_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic [CNT_W-1:0] mask,
  output logic [CNT_W-1:0] candidate
);

  logic [LFSR_W-1:0] state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEED;
    end else if (advance) begin
      state <= {1'b0, state[LFSR_W-1:1]}
             ^ (state[0] ? LFSR_TAPS : '0);
    end
  end

  assign candidate = state[CNT_W-1:0] & mask;

endmodule

// File: rtl/card_dealer.sv
// 52-card deck: fill, Fisher-Yates shuffle, deal with add strobes.
// CARD_DEALER_FREE_RUN_LFSR_EN: LFSR also runs while idle.
module card_dealer
  import card_dealer_pkg::*;
#(
  parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_shuffle,
  input  logic              i_dealReq,
  input  logic              i_dealTarget,
  output logic [CARD_W-1:0] o_newCard,
  output logic [RANK_W-1:0] o_newRank,
  output logic              o_addCardPlayer,
  output logic              o_addCardDealer,
  output logic              o_ready,
  output logic              o_deckEmpty,
  output logic [CNT_W-1:0]  o_cardsRemaining
);

  dealerState_e      state;
  dealTarget_e       target;
  logic [RANK_W-1:0] deck [DECK_SIZE];
  logic [CNT_W-1:0]  fillIdx;
  logic [RANK_W-1:0] fillRank;
  logic [CNT_W-1:0]  shufIdx;
  logic [CNT_W-1:0]  swapIdx;
  logic [CNT_W-1:0]  topIdx;
  logic              lfsrAdvance;
  logic              swapOk;
  logic              strobeHigh;
  logic              acceptShuffle;
  card_t             topCard;

`ifdef CARD_DEALER_FREE_RUN_LFSR_EN
  assign lfsrAdvance = state inside {SHUFFLE, READY, EMPTY};
`else
  assign lfsrAdvance = (state == SHUFFLE);
`endif

  card_shuffle_lfsr #(
    .SEED      (LFSR_SEED)
  ) u_lfsr (
    .clk       (i_clk),
    .rst_n     (i_reset_n),
    .advance   (lfsrAdvance),
    .mask      (shuffleMask(shufIdx)),
    .candidate (swapIdx)
  );

  assign topIdx        = o_cardsRemaining - CNT_W'(1);
  assign swapOk        = (swapIdx <= shufIdx);
  assign strobeHigh    = o_addCardPlayer | o_addCardDealer;
  assign acceptShuffle = i_shuffle
                       & ((state == READY) | (state == EMPTY));
  assign topCard.rank   = deck[topIdx];
  assign topCard.points = rankToPoints(deck[topIdx]);

  // Deck contents need no reset: FILL rebuilds them after release.
  always_ff @(posedge i_clk) begin
    if (state == FILL) begin
      deck[fillIdx] <= fillRank;
    end else if (state == SHUFFLE && swapOk) begin
      deck[shufIdx] <= deck[swapIdx];
      deck[swapIdx] <= deck[shufIdx];
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state            <= FILL;
      target           <= PLAYER;
      fillIdx          <= '0;
      fillRank         <= 4'd1;
      shufIdx          <= CNT_W'(DECK_SIZE - 1);
      o_newCard        <= '0;
      o_newRank        <= '0;
      o_addCardPlayer  <= 1'b0;
      o_addCardDealer  <= 1'b0;
      o_ready          <= 1'b0;
      o_deckEmpty      <= 1'b0;
      o_cardsRemaining <= '0;
    end else begin
      unique case (state)
        FILL: begin
          fillIdx  <= fillIdx + CNT_W'(1);
          fillRank <= (fillRank == MAX_RANK)
                    ? 4'd1 : fillRank + 4'd1;
          if (fillIdx == CNT_W'(DECK_SIZE - 1)) begin
            o_cardsRemaining <= CNT_W'(DECK_SIZE);
            shufIdx          <= CNT_W'(DECK_SIZE - 1);
            state            <= SHUFFLE;
          end
        end
        SHUFFLE: begin
          if (swapOk) begin
            if (shufIdx == CNT_W'(1)) begin
              o_ready <= 1'b1;
              state   <= READY;
            end else begin
              shufIdx <= shufIdx - CNT_W'(1);
            end
          end
        end
        READY: begin
          if (acceptShuffle) begin
            fillIdx          <= '0;
            fillRank         <= 4'd1;
            o_ready          <= 1'b0;
            o_deckEmpty      <= 1'b0;
            o_cardsRemaining <= '0;
            state            <= FILL;
          end else if (i_dealReq) begin
            target  <= dealTarget_e'(i_dealTarget);
            o_ready <= 1'b0;
            state   <= LOAD;
          end
        end
        LOAD: begin
          o_newRank        <= topCard.rank;
          o_newCard        <= topCard.points;
          o_cardsRemaining <= topIdx;
          state            <= STROBE;
        end
        STROBE: begin
          // Two cycles here: raise the strobe, then drop it.
          if (!strobeHigh) begin
            o_addCardPlayer <= (target == PLAYER);
            o_addCardDealer <= (target == DEALER);
          end else begin
            o_addCardPlayer <= 1'b0;
            o_addCardDealer <= 1'b0;
            o_ready         <= 1'b1;
            if (o_cardsRemaining == '0) begin
              o_deckEmpty <= 1'b1;
              state       <= EMPTY;
            end else begin
              state <= READY;
            end
          end
        end
        EMPTY: begin
          if (acceptShuffle) begin
            fillIdx          <= '0;
            fillRank         <= 4'd1;
            o_ready          <= 1'b0;
            o_deckEmpty      <= 1'b0;
            o_cardsRemaining <= '0;
            state            <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_card_dealer.sv
// Scoreboard bench for card_dealer with a reference shuffle model.
// Stimulus pushes expected cards; a negedge monitor checks strobes.
module tb_card_dealer;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_shuffle = 1'b0;
  logic       i_dealReq = 1'b0;
  logic       i_dealTarget = 1'b0;
  logic [4:0] o_newCard;
  logic [3:0] o_newRank;
  logic       o_addCardPlayer;
  logic       o_addCardDealer;
  logic       o_ready;
  logic       o_deckEmpty;
  logic [5:0] o_cardsRemaining;

  card_dealer #(.LFSR_SEED(16'hACE1)) dut (
    .i_clk            (i_clk),
    .i_reset_n        (i_reset_n),
    .i_shuffle        (i_shuffle),
    .i_dealReq        (i_dealReq),
    .i_dealTarget     (i_dealTarget),
    .o_newCard        (o_newCard),
    .o_newRank        (o_newRank),
    .o_addCardPlayer  (o_addCardPlayer),
    .o_addCardDealer  (o_addCardDealer),
    .o_ready          (o_ready),
    .o_deckEmpty      (o_deckEmpty),
    .o_cardsRemaining (o_cardsRemaining)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       tgt;
    logic [3:0] rank;
    logic [4:0] pts;
  } exp_t;

  int         checks = 0;
  int         errors = 0;
  exp_t       sbq[$];
  logic [15:0] mLfsr = 16'hACE1;
  logic [3:0] mDeck [52];
  int         mTop = 51;
  int         nPlayer = 0;
  int         nDealer = 0;
  int         sumPts = 0;
  int         hist [16];
  logic [3:0] seqLog[$];
  logic [3:0] seqA[$];
  logic       prevStb = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [4:0] pts(input logic [3:0] r);
    if (r == 4'd1) return 5'd11;
    if (r > 4'd10) return 5'd10;
    return {1'b0, r};
  endfunction

  function automatic logic [15:0] lfsrNext(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // Reference fill + Fisher-Yates, continuing from mLfsr.
  task automatic modelDeal();
    int i;
    int p;
    int j;
    logic [3:0] t;
    for (int k = 0; k < 52; k++) mDeck[k] = 4'((k % 13) + 1);
    i = 51;
    while (i >= 1) begin
      p = 1;
      while (p < i + 1) p = p * 2;
      j = int'(mLfsr[5:0]) & (p - 1);
      mLfsr = lfsrNext(mLfsr);
      if (j <= i) begin
        t = mDeck[i];
        mDeck[i] = mDeck[j];
        mDeck[j] = t;
        i--;
      end
    end
    mTop = 51;
  endtask

  task automatic pushExp(input logic tgt);
    exp_t e;
    e.tgt  = tgt;
    e.rank = mDeck[mTop];
    e.pts  = pts(e.rank);
    sbq.push_back(e);
    mTop--;
  endtask

  task automatic waitReady(input int maxCyc, input string name);
    int n = 0;
    while (o_ready !== 1'b1 && n < maxCyc) begin
      @(negedge i_clk);
      n++;
    end
    chk({name, "_ready"}, 32'(o_ready), 32'd1);
  endtask

  task automatic deal(input logic tgt);
    waitReady(40, "deal");
    pushExp(tgt);
    i_dealReq    = 1'b1;
    i_dealTarget = tgt;
    @(negedge i_clk);
    i_dealReq = 1'b0;
  endtask

  task automatic pulseShuffle();
    i_shuffle = 1'b1;
    @(negedge i_clk);
    i_shuffle = 1'b0;
  endtask

  always @(negedge i_clk) begin : monitor
    logic stb;
    exp_t e;
    if (i_reset_n) begin
      stb = o_addCardPlayer | o_addCardDealer;
      if (o_addCardPlayer && o_addCardDealer)
        chk("one_strobe", 32'd2, 32'd1);
      if (stb && prevStb)
        chk("strobe_width", 32'd2, 32'd1);
      if (stb && !prevStb) begin
        if (sbq.size() == 0) begin
          chk("unexpected_strobe", 32'd1, 32'd0);
        end else begin
          e = sbq.pop_front();
          chk("deal_target", 32'(o_addCardDealer), 32'(e.tgt));
          chk("deal_rank", 32'(o_newRank), 32'(e.rank));
          chk("deal_points", 32'(o_newCard), 32'(e.pts));
        end
        if (o_addCardPlayer) nPlayer++;
        if (o_addCardDealer) nDealer++;
        sumPts += int'(o_newCard);
        hist[o_newRank]++;
        seqLog.push_back(o_newRank);
      end
      prevStb = stb;
    end else begin
      prevStb = 1'b0;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] firstPts;
    logic [4:0] lastCard;
    int diffs;
    int badRanks;

    for (int k = 0; k < 16; k++) hist[k] = 0;
    #12;
    chk("rst_newCard", 32'(o_newCard), 32'd0);
    chk("rst_newRank", 32'(o_newRank), 32'd0);
    chk("rst_strobes",
        32'({o_addCardPlayer, o_addCardDealer}), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_empty", 32'(o_deckEmpty), 32'd0);
    chk("rst_count", 32'(o_cardsRemaining), 32'd0);

    @(negedge i_clk);
    i_reset_n = 1'b1;
    @(negedge i_clk);
    chk("fill_ready_low", 32'(o_ready), 32'd0);
    waitReady(2000, "init");
    chk("init_count", 32'(o_cardsRemaining), 32'd52);
    chk("init_empty", 32'(o_deckEmpty), 32'd0);
    modelDeal();

    // Cycle-accurate deal to the dealer.
    firstPts = pts(mDeck[mTop]);
    pushExp(1'b1);
    i_dealReq    = 1'b1;
    i_dealTarget = 1'b1;
    @(posedge i_clk); #1;
    i_dealReq = 1'b0;
    chk("k0_ready", 32'(o_ready), 32'd0);
    @(posedge i_clk); #1;
    chk("k1_card", 32'(o_newCard), 32'(firstPts));
    chk("k1_strobes",
        32'({o_addCardPlayer, o_addCardDealer}), 32'd0);
    chk("k1_count", 32'(o_cardsRemaining), 32'd51);
    @(posedge i_clk); #1;
    chk("k2_dealer", 32'(o_addCardDealer), 32'd1);
    chk("k2_player", 32'(o_addCardPlayer), 32'd0);
    chk("k2_card", 32'(o_newCard), 32'(firstPts));
    @(posedge i_clk); #1;
    chk("k3_dealer", 32'(o_addCardDealer), 32'd0);
    chk("k3_ready", 32'(o_ready), 32'd1);
    @(negedge i_clk);

    for (int i = 1; i < 52; i++) deal(!i[0]);
    waitReady(40, "deck_done");
    chk("n_player", 32'(nPlayer), 32'd26);
    chk("n_dealer", 32'(nDealer), 32'd26);
    chk("sum_points", 32'(sumPts), 32'd380);
    badRanks = 0;
    for (int r = 1; r <= 13; r++) if (hist[r] != 4) badRanks++;
    chk("rank_hist", 32'(badRanks), 32'd0);
    chk("done_count", 32'(o_cardsRemaining), 32'd0);
    chk("done_empty", 32'(o_deckEmpty), 32'd1);
    seqA = seqLog;

    // Deal from an empty deck is ignored.
    lastCard     = o_newCard;
    i_dealReq    = 1'b1;
    i_dealTarget = 1'b0;
    @(negedge i_clk);
    i_dealReq = 1'b0;
    repeat (6) @(negedge i_clk);
    chk("empty_strobes", 32'(nPlayer + nDealer), 32'd52);
    chk("empty_card", 32'(o_newCard), 32'(lastCard));
    chk("empty_count", 32'(o_cardsRemaining), 32'd0);
    chk("empty_flag", 32'(o_deckEmpty), 32'd1);

    pulseShuffle();
    chk("resh_ready_low", 32'(o_ready), 32'd0);
    chk("resh_empty", 32'(o_deckEmpty), 32'd0);
    waitReady(2000, "resh");
    chk("resh_count", 32'(o_cardsRemaining), 32'd52);
    modelDeal();
    deal(1'b0);
    deal(1'b1);
    deal(1'b0);
    waitReady(40, "resh_deals");

    // Shuffle wins over a simultaneous deal.
    i_shuffle    = 1'b1;
    i_dealReq    = 1'b1;
    i_dealTarget = 1'b1;
    @(negedge i_clk);
    i_shuffle = 1'b0;
    i_dealReq = 1'b0;
    chk("both_ready_low", 32'(o_ready), 32'd0);
    waitReady(2000, "both");
    chk("both_strobes", 32'(nPlayer + nDealer), 32'd55);
    chk("both_count", 32'(o_cardsRemaining), 32'd52);
    modelDeal();
    deal(1'b1);
    deal(1'b0);
    waitReady(40, "both_deals");

    // Asynchronous reset in the middle of SHUFFLE.
    pulseShuffle();
    repeat (60) @(negedge i_clk);
    chk("mid_shuf_ready", 32'(o_ready), 32'd0);
    chk("mid_shuf_count", 32'(o_cardsRemaining), 32'd52);
    #2 i_reset_n = 1'b0;
    #1;
    chk("arst_shuf_count", 32'(o_cardsRemaining), 32'd0);
    chk("arst_shuf_card", 32'(o_newCard), 32'd0);
    chk("arst_shuf_rank", 32'(o_newRank), 32'd0);
    mLfsr = 16'hACE1;
    sbq.delete();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    waitReady(2000, "rerun");
    chk("rerun_count", 32'(o_cardsRemaining), 32'd52);
    modelDeal();
    seqLog.delete();
    for (int i = 0; i < 52; i++) deal(!i[0]);
    waitReady(40, "rerun_done");
    diffs = 0;
    if (seqLog.size() != 52) diffs = 99;
    else for (int i = 0; i < 52; i++) if (seqLog[i] !== seqA[i]) diffs++;
    chk("repeat_sequence", 32'(diffs), 32'd0);

    // Asynchronous reset while a strobe is high.
    pulseShuffle();
    waitReady(2000, "pre_strobe");
    modelDeal();
    deal(1'b1);
    diffs = 0;
    while (!o_addCardDealer && diffs < 10) begin
      @(negedge i_clk);
      diffs++;
    end
    chk("strobe_seen", 32'(o_addCardDealer), 32'd1);
    #2 i_reset_n = 1'b0;
    #1;
    chk("arst_stb_strobes",
        32'({o_addCardPlayer, o_addCardDealer}), 32'd0);
    chk("arst_stb_card", 32'(o_newCard), 32'd0);
    chk("arst_stb_rank", 32'(o_newRank), 32'd0);
    chk("arst_stb_ready", 32'(o_ready), 32'd0);
    chk("arst_stb_count", 32'(o_cardsRemaining), 32'd0);
    chk("arst_stb_empty", 32'(o_deckEmpty), 32'd0);
    mLfsr = 16'hACE1;
    sbq.delete();
    modelDeal();
    @(negedge i_clk);
    i_reset_n = 1'b1;
    waitReady(2000, "post_rst");
    chk("post_rst_count", 32'(o_cardsRemaining), 32'd52);
    deal(1'b0);
    deal(1'b1);
    waitReady(40, "post_rst_deals");
    chk("sb_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
